// File: rtl/alu_share_ctrl.sv
// Round-robin sequencer sharing one external 32-bit ALU between two requesters.
// Operands are latched at grant, held for EXEC_CYCLES, and the result is returned with a done/take handshake.
module alu_share_ctrl #(
   parameter int EXEC_CYCLES = 1
) (
   input  logic        Clk,
   input  logic        Rst,
   input  logic        Req0,
   input  logic [31:0] X0,
   input  logic [31:0] Y0,
   input  logic [1:0]  Aluc0,
   input  logic        Take0,
   output logic        Ack0,
   output logic        Done0,
   input  logic        Req1,
   input  logic [31:0] X1,
   input  logic [31:0] Y1,
   input  logic [1:0]  Aluc1,
   input  logic        Take1,
   output logic        Ack1,
   output logic        Done1,
   output logic [31:0] Rout,
   output logic        Zout,
   output logic        Busy,
   output logic [31:0] AluX,
   output logic [31:0] AluY,
   output logic [1:0]  AluAluc,
   input  logic [31:0] AluR,
   input  logic        AluZ
);

   typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;

   localparam logic [3:0] CNT_LOAD = 4'(EXEC_CYCLES - 1);

   state_t      state_r, state_s;
   logic [31:0] opx_r, opx_s, opy_r, opy_s, rout_r, rout_s;
   logic [1:0]  opc_r, opc_s;
   logic [3:0]  cnt_r, cnt_s;
   logic        owner_r, owner_s, last_r, last_s;
   logic        ack0_r, ack0_s, ack1_r, ack1_s;
   logic        done0_r, done0_s, done1_r, done1_s;
   logic        zout_r, zout_s, busy_r, busy_s;
   logic        take_s;

   // Next-state and next-output computation
   always_comb begin
      state_s = state_r;
      opx_s   = opx_r;
      opy_s   = opy_r;
      opc_s   = opc_r;
      cnt_s   = cnt_r;
      owner_s = owner_r;
      last_s  = last_r;
      ack0_s  = 1'b0;
      ack1_s  = 1'b0;
      done0_s = done0_r;
      done1_s = done1_r;
      rout_s  = rout_r;
      zout_s  = zout_r;
      take_s  = owner_r ? Take1 : Take0;
      case (state_r)
         IDLE: begin
            // On contention the requester that was not served last wins
            if (Req0 && (!Req1 || last_r)) begin
               opx_s   = X0;
               opy_s   = Y0;
               opc_s   = Aluc0;
               ack0_s  = 1'b1;
               owner_s = 1'b0;
               last_s  = 1'b0;
               cnt_s   = CNT_LOAD;
               state_s = EXEC;
            end else if (Req1) begin
               opx_s   = X1;
               opy_s   = Y1;
               opc_s   = Aluc1;
               ack1_s  = 1'b1;
               owner_s = 1'b1;
               last_s  = 1'b1;
               cnt_s   = CNT_LOAD;
               state_s = EXEC;
            end else begin
               state_s = IDLE;
            end
         end
         EXEC: begin
            if (cnt_r != 4'd0) begin
               cnt_s = cnt_r - 4'd1;
            end else begin
               rout_s  = AluR;
               zout_s  = AluZ;
               state_s = RESP;
               if (owner_r) begin
                  done1_s = 1'b1;
               end else begin
                  done0_s = 1'b1;
               end
            end
         end
         RESP: begin
            if (take_s) begin
               done0_s = 1'b0;
               done1_s = 1'b0;
               state_s = IDLE;
            end else begin
               state_s = RESP;
            end
         end
         default: begin
            state_s = IDLE;
         end
      endcase
      busy_s = (state_s != IDLE);
   end

   // State and output registers with synchronous reset
   always_ff @(posedge Clk) begin
      if (Rst) begin
         state_r <= IDLE;
         opx_r   <= 32'd0;
         opy_r   <= 32'd0;
         opc_r   <= 2'd0;
         cnt_r   <= 4'd0;
         owner_r <= 1'b0;
         last_r  <= 1'b1;
         ack0_r  <= 1'b0;
         ack1_r  <= 1'b0;
         done0_r <= 1'b0;
         done1_r <= 1'b0;
         rout_r  <= 32'd0;
         zout_r  <= 1'b0;
         busy_r  <= 1'b0;
      end else begin
         state_r <= state_s;
         opx_r   <= opx_s;
         opy_r   <= opy_s;
         opc_r   <= opc_s;
         cnt_r   <= cnt_s;
         owner_r <= owner_s;
         last_r  <= last_s;
         ack0_r  <= ack0_s;
         ack1_r  <= ack1_s;
         done0_r <= done0_s;
         done1_r <= done1_s;
         rout_r  <= rout_s;
         zout_r  <= zout_s;
         busy_r  <= busy_s;
      end
   end

   assign Ack0    = ack0_r;
   assign Ack1    = ack1_r;
   assign Done0   = done0_r;
   assign Done1   = done1_r;
   assign Rout    = rout_r;
   assign Zout    = zout_r;
   assign Busy    = busy_r;
   assign AluX    = opx_r;
   assign AluY    = opy_r;
   assign AluAluc = opc_r;

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Scoreboard bench for alu_share_ctrl: instance a (EXEC_CYCLES=1) carries most traffic,
// instance b (EXEC_CYCLES=4) covers the longer settle time.
module tb_alu_share_ctrl;

   typedef struct {
      logic        owner;
      logic [31:0] r;
      logic        z;
   } exp_t;

   logic        clk, Rst;
   logic        req0_a, req1_a, req0_b, req1_b;
   logic [31:0] X0, Y0, X1, Y1;
   logic [1:0]  Aluc0, Aluc1;
   logic        Take0, Take1;

   logic        ack0_a, ack1_a, done0_a, done1_a, zout_a, busy_a, aluz_a;
   logic [31:0] rout_a, alux_a, aluy_a, alur_a;
   logic [1:0]  aluc_a;
   logic        ack0_b, ack1_b, done0_b, done1_b, zout_b, busy_b, aluz_b;
   logic [31:0] rout_b, alux_b, aluy_b, alur_b;
   logic [1:0]  aluc_b;

   int   n_chk = 0;
   int   n_err = 0;
   exp_t sb_q[$];
   logic d0_prev = 1'b0;
   logic d1_prev = 1'b0;

   function automatic logic [31:0] alu_f(input logic [31:0] x, input logic [31:0] y, input logic [1:0] c);
      case (c)
         2'd0:    return x + y;
         2'd1:    return x - y;
         2'd2:    return x & y;
         default: return x | y;
      endcase
   endfunction

   assign alur_a = alu_f(alux_a, aluy_a, aluc_a);
   assign aluz_a = (alur_a == 32'd0);
   assign alur_b = alu_f(alux_b, aluy_b, aluc_b);
   assign aluz_b = (alur_b == 32'd0);

   alu_share_ctrl #(.EXEC_CYCLES(1)) u_dut_a (
      .Clk(clk), .Rst(Rst),
      .Req0(req0_a), .X0(X0), .Y0(Y0), .Aluc0(Aluc0), .Take0(Take0), .Ack0(ack0_a), .Done0(done0_a),
      .Req1(req1_a), .X1(X1), .Y1(Y1), .Aluc1(Aluc1), .Take1(Take1), .Ack1(ack1_a), .Done1(done1_a),
      .Rout(rout_a), .Zout(zout_a), .Busy(busy_a),
      .AluX(alux_a), .AluY(aluy_a), .AluAluc(aluc_a), .AluR(alur_a), .AluZ(aluz_a)
   );

   alu_share_ctrl #(.EXEC_CYCLES(4)) u_dut_b (
      .Clk(clk), .Rst(Rst),
      .Req0(req0_b), .X0(X0), .Y0(Y0), .Aluc0(Aluc0), .Take0(Take0), .Ack0(ack0_b), .Done0(done0_b),
      .Req1(req1_b), .X1(X1), .Y1(Y1), .Aluc1(Aluc1), .Take1(Take1), .Ack1(ack1_b), .Done1(done1_b),
      .Rout(rout_b), .Zout(zout_b), .Busy(busy_b),
      .AluX(alux_b), .AluY(aluy_b), .AluAluc(aluc_b), .AluR(alur_b), .AluZ(aluz_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic owner, input logic [31:0] r, input logic z);
      exp_t e;
      e.owner = owner;
      e.r     = r;
      e.z     = z;
      sb_q.push_back(e);
   endtask

   task automatic wait_ack(output int n);
      n = 0;
      do begin
         tick();
         n++;
      end while (!(ack0_a || ack1_a) && n < 8);
      chk("ack_seen", {31'd0, ack0_a | ack1_a}, 32'd1);
      chk("ack_one", {31'd0, ack0_a & ack1_a}, 32'd0);
   endtask

   // Scoreboard: every rising Done on instance a is matched against the oldest expectation
   always @(negedge clk) begin
      if ((done0_a && !d0_prev) || (done1_a && !d1_prev)) begin
         if (sb_q.size() == 0) begin
            chk("sb_unexpected_done", {31'd0, done1_a}, 32'hFFFFFFFF);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            chk("sb_owner", {30'd0, done1_a, done0_a}, e.owner ? 32'd2 : 32'd1);
            chk("sb_rout", rout_a, e.r);
            chk("sb_zout", {31'd0, zout_a}, {31'd0, e.z});
         end
      end
      d0_prev <= done0_a;
      d1_prev <= done1_a;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   logic [31:0] t6_x[8] = '{32'hFFFFFFFF, 32'd7, 32'h0000F0F0, 32'd0, 32'd1, 32'd5, 32'h000000AA, 32'd1};
   logic [31:0] t6_y[8] = '{32'd1, 32'd7, 32'h00000F0F, 32'd0, 32'd2, 32'd9, 32'h000000FF, 32'd2};
   logic [1:0]  t6_c[8] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3};
   logic [31:0] t6_r[8] = '{32'd0, 32'd0, 32'd0, 32'd0, 32'd3, 32'hFFFFFFFC, 32'h000000AA, 32'd3};

   initial begin
      int n;
      Rst = 1'b1;
      req0_a = 1'b0; req1_a = 1'b0; req0_b = 1'b0; req1_b = 1'b0;
      X0 = 32'd0; Y0 = 32'd0; X1 = 32'd0; Y1 = 32'd0;
      Aluc0 = 2'd0; Aluc1 = 2'd0; Take0 = 1'b0; Take1 = 1'b0;
      tick(); tick();
      chk("rst_flags", {26'd0, ack0_a, ack1_a, done0_a, done1_a, busy_a, zout_a}, 32'd0);
      chk("rst_rout", rout_a, 32'd0);
      chk("rst_alu", alux_a | aluy_a | {30'd0, aluc_a}, 32'd0);
      Rst = 1'b0;

      // 1: single add with Take tied high
      X0 = 32'd5; Y0 = 32'd3; Aluc0 = 2'd0; Take0 = 1'b1; req0_a = 1'b1;
      push(1'b0, 32'd8, 1'b0);
      tick();
      chk("t1_ack", {31'd0, ack0_a}, 32'd1);
      chk("t1_alux", alux_a, 32'd5);
      req0_a = 1'b0;
      tick();
      chk("t1_ack_pulse", {31'd0, ack0_a}, 32'd0);
      chk("t1_done", {31'd0, done0_a}, 32'd1);
      tick();
      chk("t1_done_drop", {31'd0, done0_a}, 32'd0);
      chk("t1_busy", {31'd0, busy_a}, 32'd0);

      // 2: both requesters hold requests, expect 0,1,0,1 with a bubble
      Rst = 1'b1; tick(); Rst = 1'b0;
      X0 = 32'd10; Y0 = 32'd4; Aluc0 = 2'd1; X1 = 32'hF0; Y1 = 32'h3C; Aluc1 = 2'd2;
      Take0 = 1'b1; Take1 = 1'b1; req0_a = 1'b1; req1_a = 1'b1;
      for (int k = 0; k < 4; k++) begin
         push(k[0], k[0] ? 32'h30 : 32'd6, 1'b0);
      end
      for (int k = 0; k < 4; k++) begin
         wait_ack(n);
         chk("t2_order", {31'd0, ack1_a}, {31'd0, k[0]});
         if (k > 0) chk("t2_gap", n, 32'd3);
      end
      req0_a = 1'b0; req1_a = 1'b0;
      tick(); tick(); tick();
      chk("t2_idle", {31'd0, busy_a}, 32'd0);

      // 3: Take0 withheld while Req1 and Take1 are active
      X0 = 32'h0F00; Y0 = 32'h00F0; Aluc0 = 2'd3; Take0 = 1'b0; Take1 = 1'b1; req0_a = 1'b1;
      push(1'b0, 32'h0FF0, 1'b0);
      push(1'b1, 32'h30, 1'b0);
      wait_ack(n);
      chk("t3_ack0", {31'd0, ack0_a}, 32'd1);
      req0_a = 1'b0; req1_a = 1'b1;
      tick();
      for (int k = 0; k < 5; k++) begin
         tick();
         chk("t3_hold_done", {31'd0, done0_a}, 32'd1);
         chk("t3_hold_rout", rout_a, 32'h0FF0);
         chk("t3_no_ack1", {31'd0, ack1_a}, 32'd0);
      end
      Take0 = 1'b1;
      tick();
      chk("t3_take", {31'd0, done0_a}, 32'd0);
      chk("t3_bubble", {31'd0, ack1_a}, 32'd0);
      Take0 = 1'b0;
      tick();
      chk("t3_ack1", {31'd0, ack1_a}, 32'd1);
      req1_a = 1'b0;
      tick(); tick();
      Take1 = 1'b0;

      // 4: EXEC_CYCLES=4 instance, operand changed after Ack
      X0 = 32'hFFFFFFFF; Y0 = 32'd1; Aluc0 = 2'd0; req0_b = 1'b1;
      tick();
      chk("t4_ack", {31'd0, ack0_b}, 32'd1);
      req0_b = 1'b0; X0 = 32'd0;
      for (int k = 1; k < 4; k++) begin
         tick();
         chk("t4_no_done", {31'd0, done0_b}, 32'd0);
         chk("t4_alux_hold", alux_b, 32'hFFFFFFFF);
      end
      tick();
      chk("t4_done", {31'd0, done0_b}, 32'd1);
      chk("t4_rout", rout_b, 32'd0);
      chk("t4_zout", {31'd0, zout_b}, 32'd1);
      Take0 = 1'b1;
      tick();
      chk("t4_take", {31'd0, done0_b}, 32'd0);
      Take0 = 1'b0;

      // 5: reset during EXEC abandons the operation and restores priority to 0
      X0 = 32'd10; Y0 = 32'd4; Aluc0 = 2'd1; req0_a = 1'b1;
      wait_ack(n);
      chk("t5_ack0", {31'd0, ack0_a}, 32'd1);
      Rst = 1'b1; req0_a = 1'b0;
      tick();
      chk("t5_flags", {26'd0, ack0_a, ack1_a, done0_a, done1_a, busy_a, zout_a}, 32'd0);
      chk("t5_rout", rout_a, 32'd0);
      chk("t5_alux", alux_a, 32'd0);
      Rst = 1'b0;
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("t5_no_done", {31'd0, done0_a}, 32'd0);
      end
      X1 = 32'hF0; Y1 = 32'h3C; Aluc1 = 2'd2; Take0 = 1'b1; Take1 = 1'b1;
      req0_a = 1'b1; req1_a = 1'b1;
      push(1'b0, 32'd6, 1'b0);
      push(1'b1, 32'h30, 1'b0);
      wait_ack(n);
      chk("t5_first", {30'd0, ack0_a, ack1_a}, 32'd2);
      req0_a = 1'b0;
      wait_ack(n);
      chk("t5_second", {31'd0, ack1_a}, 32'd1);
      req1_a = 1'b0;
      tick(); tick(); tick();
      Take0 = 1'b0; Take1 = 1'b0;

      // 6: Z flag across all ALU ops, held through RESP
      for (int k = 0; k < 8; k++) begin
         X0 = t6_x[k]; Y0 = t6_y[k]; Aluc0 = t6_c[k]; req0_a = 1'b1;
         push(1'b0, t6_r[k], t6_r[k] == 32'd0);
         wait_ack(n);
         req0_a = 1'b0;
         tick();
         chk("t6_done", {31'd0, done0_a}, 32'd1);
         for (int j = 0; j < 2; j++) begin
            tick();
            chk("t6_zhold", {31'd0, zout_a}, {31'd0, t6_r[k] == 32'd0});
            chk("t6_rhold", rout_a, t6_r[k]);
         end
         Take0 = 1'b1;
         tick();
         Take0 = 1'b0;
         tick();
      end

      chk("sb_drain", sb_q.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
